board_renderer: RTL and testbench

//  Consumer end of the game-logic piece interface. Holds a colour-index copy of the locked board
//  and turns VGA scan coordinates into 12-bit RGB each pixel clock. Overlays the falling piece
//  (4 cells + colour index) on locked cells. Locked pieces are written through a ready/valid port.

---
 rtl/board_renderer.sv | 245 ++++++++++++++++++++++++
 tb/tb_board_renderer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_renderer.sv
// Board renderer: keeps a colour-index copy of the locked playfield in a
// block RAM, accepts locked pieces over a ready/valid port, and converts
// VGA scan coordinates into 12-bit RGB through a two-stage pixel pipeline.
// The falling piece is overlaid on the locked cells.
module board_renderer #(
   parameter int          BOARD_W    = 12,
   parameter int          BOARD_H    = 19,
   parameter int          TILE_LOG2  = 4,
   parameter int          ORIGIN_X   = 224,
   parameter int          ORIGIN_Y   = 88,
   parameter logic [11:0] BORDER_RGB = 12'h888
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       blank,
   input  logic [5:0] pieceX1,
   input  logic [5:0] pieceX2,
   input  logic [5:0] pieceX3,
   input  logic [5:0] pieceX4,
   input  logic [6:0] pieceY1,
   input  logic [6:0] pieceY2,
   input  logic [6:0] pieceY3,
   input  logic [6:0] pieceY4,
   input  logic [3:0] pieceColor,
   input  logic       lock_valid,
   input  logic [5:0] lockX1,
   input  logic [5:0] lockX2,
   input  logic [5:0] lockX3,
   input  logic [5:0] lockX4,
   input  logic [6:0] lockY1,
   input  logic [6:0] lockY2,
   input  logic [6:0] lockY3,
   input  logic [6:0] lockY4,
   input  logic [3:0] lockColor,
   output logic       lock_ready,
   output logic       clear_busy,
   output logic [3:0] Red,
   output logic [3:0] Green,
   output logic [3:0] Blue
);

   localparam int                CELLS     = BOARD_W * BOARD_H;
   localparam logic [7:0]        LAST_ADDR = 8'(CELLS - 1);
   localparam logic [7:0]        W8        = 8'(BOARD_W);
   localparam logic [5:0]        W6        = 6'(BOARD_W);
   localparam logic [6:0]        H7        = 7'(BOARD_H);
   localparam logic signed [10:0] W_S      = 11'(BOARD_W);
   localparam logic signed [10:0] H_S      = 11'(BOARD_H);
   localparam logic signed [10:0] OX_S     = 11'(ORIGIN_X);
   localparam logic signed [10:0] OY_S     = 11'(ORIGIN_Y);
   localparam logic signed [10:0] ZERO_S   = '0;
   localparam logic signed [10:0] NEG1_S   = '1;

   typedef enum logic [1:0] {CLEAR, IDLE, WR} state_t;

   state_t     state_reg, state_next;
   logic [7:0] clr_addr_reg, clr_addr_next;
   logic [1:0] idx_reg, idx_next;
   logic       capture;
   logic       we;
   logic [7:0] waddr, raddr;
   logic [3:0] wdata, ram_q;
   logic [3:0] mem [CELLS];

   logic [5:0] lock_x [4];
   logic [6:0] lock_y [4];
   logic [5:0] piece_x [4];
   logic [6:0] piece_y [4];
   logic [5:0] cap_x_reg [4];
   logic [6:0] cap_y_reg [4];
   logic [3:0] cap_color_reg;
   logic [5:0] cur_x;
   logic [6:0] cur_y;

   assign lock_x  = '{lockX1, lockX2, lockX3, lockX4};
   assign lock_y  = '{lockY1, lockY2, lockY3, lockY4};
   assign piece_x = '{pieceX1, pieceX2, pieceX3, pieceX4};
   assign piece_y = '{pieceY1, pieceY2, pieceY3, pieceY4};
   assign cur_x   = cap_x_reg[idx_reg];
   assign cur_y   = cap_y_reg[idx_reg];

   function automatic logic [11:0] palette(input logic [3:0] i);
      case (i)
         4'h0: palette = 12'h111;  4'h1: palette = 12'hF00;
         4'h2: palette = 12'h0F0;  4'h3: palette = 12'h00F;
         4'h4: palette = 12'hFF0;  4'h5: palette = 12'hF0F;
         4'h6: palette = 12'h0FF;  4'h7: palette = 12'hF80;
         4'h8: palette = 12'h80F;  4'h9: palette = 12'hFFF;
         4'hA: palette = 12'hF88;  4'hB: palette = 12'h8F8;
         4'hC: palette = 12'h88F;  4'hD: palette = 12'h840;
         4'hE: palette = 12'h048;  default: palette = 12'h444;
      endcase
   endfunction

   // State register, clear pointer and cell index of the lock write-out
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg    <= CLEAR;
         clr_addr_reg <= '0;
         idx_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         clr_addr_reg <= clr_addr_next;
         idx_reg      <= idx_next;
      end
   end

   // Latch all four cells and the colour when a lock request is accepted
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 4; i++) begin
            cap_x_reg[i] <= '0;
            cap_y_reg[i] <= '0;
         end
         cap_color_reg <= '0;
      end else if (capture) begin
         for (int i = 0; i < 4; i++) begin
            cap_x_reg[i] <= lock_x[i];
            cap_y_reg[i] <= lock_y[i];
         end
         cap_color_reg <= lockColor;
      end
   end

   // Next-state logic: wipe the board, wait for a lock, write four cells
   always_comb begin
      state_next    = state_reg;
      clr_addr_next = clr_addr_reg;
      idx_next      = idx_reg;
      we            = 1'b0;
      waddr         = '0;
      wdata         = '0;
      capture       = 1'b0;
      lock_ready    = 1'b0;
      clear_busy    = 1'b0;
      unique case (state_reg)
         CLEAR: begin
            clear_busy    = 1'b1;
            we            = 1'b1;
            waddr         = clr_addr_reg;
            clr_addr_next = clr_addr_reg + 8'd1;
            if (clr_addr_reg == LAST_ADDR) begin
               clr_addr_next = '0;
               state_next    = IDLE;
            end
         end
         IDLE: begin
            lock_ready = 1'b1;
            if (lock_valid) begin
               capture    = 1'b1;
               idx_next   = '0;
               state_next = WR;
            end
         end
         WR: begin
            // Off-board cells still consume their slot so a lock is always 4 cycles
            if (cur_x < W6 && cur_y < H7) begin
               we    = 1'b1;
               waddr = 8'(cur_y) * W8 + 8'(cur_x);
               wdata = cap_color_reg;
            end
            idx_next = idx_reg + 2'd1;
            if (idx_reg == 2'd3) state_next = IDLE;
         end
         default: state_next = CLEAR;
      endcase
   end

   // Board RAM: read is registered and sees the value from before a same-cycle write
   always_ff @(posedge Clk) begin
      if (we) mem[waddr] <= wdata;
      ram_q <= mem[raddr];
   end

   // Stage 0: tile coordinates from scan position; arithmetic shift keeps negatives negative
   logic signed [10:0] rel_x, rel_y, tx, ty;
   logic               s0_board, s0_border;

   assign rel_x     = $signed({1'b0, DrawX}) - OX_S;
   assign rel_y     = $signed({1'b0, DrawY}) - OY_S;
   assign tx        = rel_x >>> TILE_LOG2;
   assign ty        = rel_y >>> TILE_LOG2;
   assign s0_board  = (tx >= ZERO_S) && (tx < W_S) && (ty >= ZERO_S) && (ty < H_S);
   assign s0_border = (tx >= NEG1_S) && (tx <= W_S) && (ty >= NEG1_S) && (ty <= H_S) && !s0_board;
   assign raddr     = s0_board ? (8'(ty[4:0]) * W8 + 8'(tx[3:0])) : 8'd0;

   logic [5:0] tx_reg;
   logic [6:0] ty_reg;
   logic       board_reg, border_reg, blank_reg;

   // Stage 0 register: tile position, region flags and blank travel alongside the RAM read
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tx_reg     <= '0;
         ty_reg     <= '0;
         board_reg  <= 1'b0;
         border_reg <= 1'b0;
         blank_reg  <= 1'b0;
      end else begin
         tx_reg     <= tx[5:0];
         ty_reg     <= ty[6:0];
         board_reg  <= s0_board;
         border_reg <= s0_border;
         blank_reg  <= blank;
      end
   end

   // Stage 1: falling piece overrides the locked colour on any matching cell
   logic [3:0]  cell_hit;
   logic        piece_hit;
   logic [3:0]  pix_idx;
   logic [11:0] rgb_next, rgb_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_hit
         assign cell_hit[gi] = (piece_x[gi] == tx_reg) && (piece_y[gi] == ty_reg);
      end
   endgenerate

   assign piece_hit = (pieceColor != 4'd0) && (|cell_hit);
   assign pix_idx   = piece_hit ? pieceColor : ram_q;

   // Colour select: board, frame or background; black when blanked or clearing
   always_comb begin
      rgb_next = 12'h000;
      if (blank_reg && !clear_busy) begin
         if (board_reg)       rgb_next = palette(pix_idx);
         else if (border_reg) rgb_next = BORDER_RGB;
      end
   end

   // Output register driving the DAC pins
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) rgb_reg <= 12'h000;
      else          rgb_reg <= rgb_next;
   end

   assign Red   = rgb_reg[11:8];
   assign Green = rgb_reg[7:4];
   assign Blue  = rgb_reg[3:0];

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: constant vector table, hand-built multi-cycle
// sequences (clear length, lock timing, read-during-write, mid-lock reset)
// and randomized pixels/locks checked against a tile-level board model.
module tb_board_renderer;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b1;
   logic [9:0] DrawX = '0, DrawY = '0;
   logic       blank = 1'b0;
   logic [5:0] pieceX1 = '0, pieceX2 = '0, pieceX3 = '0, pieceX4 = '0;
   logic [6:0] pieceY1 = '0, pieceY2 = '0, pieceY3 = '0, pieceY4 = '0;
   logic [3:0] pieceColor = '0;
   logic       lock_valid = 1'b0;
   logic [5:0] lockX1 = '0, lockX2 = '0, lockX3 = '0, lockX4 = '0;
   logic [6:0] lockY1 = '0, lockY2 = '0, lockY3 = '0, lockY4 = '0;
   logic [3:0] lockColor = '0;
   logic       lock_ready, clear_busy;
   logic [3:0] Red, Green, Blue;

   board_renderer dut (
      .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .pieceX1(pieceX1), .pieceX2(pieceX2), .pieceX3(pieceX3), .pieceX4(pieceX4),
      .pieceY1(pieceY1), .pieceY2(pieceY2), .pieceY3(pieceY3), .pieceY4(pieceY4),
      .pieceColor(pieceColor), .lock_valid(lock_valid),
      .lockX1(lockX1), .lockX2(lockX2), .lockX3(lockX3), .lockX4(lockX4),
      .lockY1(lockY1), .lockY2(lockY2), .lockY3(lockY3), .lockY4(lockY4),
      .lockColor(lockColor), .lock_ready(lock_ready), .clear_busy(clear_busy),
      .Red(Red), .Green(Green), .Blue(Blue)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;
   logic [11:0] pal [16] = '{12'h111, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF80,
                             12'h80F, 12'hFFF, 12'hF88, 12'h8F8, 12'h88F, 12'h840, 12'h048, 12'h444};
   int board [19][12];
   int pxs [4], pys [4], pcol;
   int lxs [4], lys [4];

   typedef struct {
      int          x;
      int          y;
      bit          b;
      int          pc;
      logic [11:0] exp;
   } vec_t;
   vec_t vecs [20];

   function automatic int fdiv16(int v);
      return (v >= 0) ? v / 16 : -((-v + 15) / 16);
   endfunction

   // Reference: tile lookup by floor division, piece overlay, frame, background
   function automatic logic [11:0] model_rgb(int x, int y, bit b);
      int tx, ty, idx;
      tx = fdiv16(x - 224);
      ty = fdiv16(y - 88);
      if (!b) return 12'h000;
      if (tx >= 0 && tx < 12 && ty >= 0 && ty < 19) begin
         idx = board[ty][tx];
         for (int k = 0; k < 4; k++)
            if (pcol != 0 && pxs[k] == tx && pys[k] == ty) idx = pcol;
         return pal[idx];
      end
      if (tx >= -1 && tx <= 12 && ty >= -1 && ty <= 19) return 12'h888;
      return 12'h000;
   endfunction

   task automatic check12(string name, logic [11:0] act, logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %03h expected %03h", name, act, exp);
      end else
         $display("ok   %s: %03h", name, act);
   endtask

   task automatic check_int(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else
         $display("ok   %s: %0d", name, act);
   endtask

   task automatic drive_piece();
      pieceX1 = 6'(pxs[0]); pieceX2 = 6'(pxs[1]); pieceX3 = 6'(pxs[2]); pieceX4 = 6'(pxs[3]);
      pieceY1 = 7'(pys[0]); pieceY2 = 7'(pys[1]); pieceY3 = 7'(pys[2]); pieceY4 = 7'(pys[3]);
      pieceColor = 4'(pcol);
   endtask

   task automatic drive_lock(int col);
      lockX1 = 6'(lxs[0]); lockX2 = 6'(lxs[1]); lockX3 = 6'(lxs[2]); lockX4 = 6'(lxs[3]);
      lockY1 = 7'(lys[0]); lockY2 = 7'(lys[1]); lockY3 = 7'(lys[2]); lockY4 = 7'(lys[3]);
      lockColor = 4'(col);
   endtask

   task automatic model_lock(int col);
      for (int k = 0; k < 4; k++)
         if (lxs[k] < 12 && lys[k] < 19) board[lys[k]][lxs[k]] = col;
   endtask

   // Called on a falling edge: present coordinates, read result two edges later
   task automatic pix(string name, int x, int y, bit b, logic [11:0] exp);
      DrawX = 10'(x); DrawY = 10'(y); blank = b;
      @(negedge Clk);
      @(negedge Clk);
      check12(name, {Red, Green, Blue}, exp);
   endtask

   task automatic wait_ready(output bit ok);
      int n;
      n = 0;
      while (!lock_ready && n < 400) begin
         @(negedge Clk);
         n++;
      end
      ok = lock_ready;
   endtask

   task automatic count_low(output int low);
      low = 0;
      while (!lock_ready && low < 20) begin
         low++;
         @(negedge Clk);
      end
   endtask

   task automatic do_lock(string name, int col);
      bit ok;
      int low;
      drive_lock(col);
      lock_valid = 1'b1;
      wait_ready(ok);
      check_int({name, "_accept"}, int'(ok), 1);
      @(negedge Clk);
      lock_valid = 1'b0;
      count_low(low);
      check_int({name, "_busy_cycles"}, low, 4);
      model_lock(col);
   endtask

   task automatic run_clear(string name);
      int  n;
      bit  black_ok;
      n = 0;
      black_ok = 1'b1;
      while (clear_busy && n < 1000) begin
         n++;
         if ({Red, Green, Blue} != 12'h000) black_ok = 1'b0;
         @(negedge Clk);
      end
      check_int({name, "_cycles"}, n, 228);
      check_int({name, "_black"}, int'(black_ok), 1);
      check_int({name, "_ready_after"}, int'(lock_ready), 1);
      for (int r = 0; r < 19; r++)
         for (int c = 0; c < 12; c++) board[r][c] = 0;
   endtask

   initial begin
      bit ok;
      int low;
      int x, y, k;
      bit b;

      for (int r = 0; r < 19; r++)
         for (int c = 0; c < 12; c++) board[r][c] = 0;
      pcol = 0;
      for (int i = 0; i < 4; i++) begin pxs[i] = 0; pys[i] = 0; end

      // Reset state
      #2 Reset_n = 1'b0;
      #1;
      check12("reset_rgb", {Red, Green, Blue}, 12'h000);
      check_int("reset_lock_ready", int'(lock_ready), 0);
      check_int("reset_clear_busy", int'(clear_busy), 1);
      DrawX = 10'd240; DrawY = 10'd100; blank = 1'b1;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      run_clear("clear");
      pix("after_clear", 240, 100, 1'b1, model_rgb(240, 100, 1'b1));

      // Bottom-left square, then a lock with two off-board cells
      lxs = '{0, 1, 0, 1};  lys = '{18, 18, 17, 17};
      do_lock("lock_square", 2);
      lxs = '{5, 12, 0, 7}; lys = '{0, 3, 19, 7};
      do_lock("lock_skip", 3);

      pxs = '{5, 12, 6, 0}; pys = '{0, 0, 1, 18};
      vecs[0]  = '{224, 376, 1'b1, 0, 12'h0F0};
      vecs[1]  = '{224, 376, 1'b1, 1, 12'hF00};
      vecs[2]  = '{304,  88, 1'b1, 1, 12'hF00};
      vecs[3]  = '{304,  88, 1'b1, 0, 12'h00F};
      vecs[4]  = '{208, 100, 1'b1, 0, 12'h888};
      vecs[5]  = '{  0, 100, 1'b1, 0, 12'h000};
      vecs[6]  = '{304,  88, 1'b0, 1, 12'h000};
      vecs[7]  = '{223,  88, 1'b1, 0, 12'h888};
      vecs[8]  = '{207, 100, 1'b1, 0, 12'h000};
      vecs[9]  = '{416,  88, 1'b1, 1, 12'h888};
      vecs[10] = '{432, 100, 1'b1, 0, 12'h000};
      vecs[11] = '{224, 392, 1'b1, 0, 12'h888};
      vecs[12] = '{240, 100, 1'b1, 0, 12'h111};
      vecs[13] = '{320, 104, 1'b1, 3, 12'h00F};
      vecs[14] = '{208,  72, 1'b1, 0, 12'h888};
      vecs[15] = '{1023, 1023, 1'b1, 0, 12'h000};
      vecs[16] = '{224, 152, 1'b1, 0, 12'h111};
      vecs[17] = '{336, 200, 1'b1, 0, 12'h00F};
      vecs[18] = '{239, 375, 1'b1, 0, 12'h0F0};
      vecs[19] = '{431, 391, 1'b1, 0, 12'h888};
      for (int i = 0; i < 20; i++) begin
         pcol = vecs[i].pc;
         drive_piece();
         pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].b, vecs[i].exp);
      end

      // Pixel read of a cell on the very edge it is written shows the old colour
      pcol = 0;
      drive_piece();
      lxs = '{3, 13, 13, 13}; lys = '{3, 0, 0, 0};
      drive_lock(5);
      lock_valid = 1'b1;
      wait_ready(ok);
      check_int("rw_accept", int'(ok), 1);
      @(negedge Clk);
      lock_valid = 1'b0;
      DrawX = 10'd272; DrawY = 10'd136; blank = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      check12("rw_same_cycle_old", {Red, Green, Blue}, model_rgb(272, 136, 1'b1));
      model_lock(5);
      count_low(low);
      pix("rw_after", 272, 136, 1'b1, model_rgb(272, 136, 1'b1));

      // lock_valid held through WR: second request taken only back in IDLE
      lxs = '{2, 3, 4, 5}; lys = '{10, 10, 10, 10};
      drive_lock(6);
      lock_valid = 1'b1;
      wait_ready(ok);
      check_int("held_accept_a", int'(ok), 1);
      @(negedge Clk);
      model_lock(6);
      lys = '{11, 11, 11, 11};
      drive_lock(7);
      count_low(low);
      check_int("held_busy_a", low, 4);
      @(negedge Clk);
      lock_valid = 1'b0;
      count_low(low);
      check_int("held_busy_b", low, 4);
      model_lock(7);
      pix("held_cell_a", 256, 248, 1'b1, model_rgb(256, 248, 1'b1));
      pix("held_cell_b", 312, 270, 1'b1, model_rgb(312, 270, 1'b1));

      // Random locks followed by random pixels with a random falling piece
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 4; j++) begin
            lxs[j] = int'($urandom_range(0, 13));
            lys[j] = int'($urandom_range(0, 20));
         end
         do_lock($sformatf("rand_lock%0d", i), int'($urandom_range(1, 15)));
      end
      for (int i = 0; i < 150; i++) begin
         pcol = int'($urandom_range(0, 15));
         for (int j = 0; j < 4; j++) begin
            pxs[j] = int'($urandom_range(0, 13));
            pys[j] = int'($urandom_range(0, 20));
         end
         drive_piece();
         if ($urandom_range(0, 1) == 1) begin
            k = int'($urandom_range(0, 3));
            x = 224 + pxs[k] * 16 + int'($urandom_range(0, 15));
            y = 88 + pys[k] * 16 + int'($urandom_range(0, 15));
         end else begin
            x = int'($urandom_range(190, 450));
            y = int'($urandom_range(60, 420));
         end
         b = ($urandom_range(0, 7) != 0);
         pix($sformatf("rand_pix%0d", i), x, y, b, model_rgb(x, y, b));
      end

      // Reset in the middle of a lock write, then a full re-clear
      pcol = 0;
      drive_piece();
      DrawX = 10'd240; DrawY = 10'd100; blank = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      lxs = '{8, 9, 10, 11}; lys = '{8, 8, 8, 8};
      drive_lock(9);
      lock_valid = 1'b1;
      wait_ready(ok);
      check_int("midwr_accept", int'(ok), 1);
      @(negedge Clk);
      lock_valid = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      check12("midwr_reset_rgb", {Red, Green, Blue}, 12'h000);
      check_int("midwr_reset_ready", int'(lock_ready), 0);
      check_int("midwr_reset_busy", int'(clear_busy), 1);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      run_clear("reclear");
      for (int r = 0; r < 19; r++)
         for (int c = 0; c < 12; c++)
            pix($sformatf("scan_r%0d_c%0d", r, c), 224 + c * 16 + 8, 88 + r * 16 + 8, 1'b1,
                model_rgb(224 + c * 16 + 8, 88 + r * 16 + 8, 1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
